// File: rtl/usfft_bin_collect_pkg.sv
// Shared definitions for the SFFT bin-collection stage.
//   state_t   : collector FSM states (IDLE / RUN / DONE)
//   NUM_CH    : number of butterfly output bitstreams collected together
//   usfft_ow  : signed result width derived from the counter bit width
package usfft_bin_collect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_CH = 4;

    // A count of 0..2^bw maps to a bipolar value of -2^bw..+2^bw, which needs bw+2 signed bits.
    function automatic int unsigned usfft_ow(input int unsigned bw);
        return bw + 2;
    endfunction

endpackage

// File: rtl/usfft_ones_cnt.sv
// Ones counter for one unary bitstream.
//   iClk   : clock, rising edge
//   iRstN  : asynchronous active-low reset
//   iClr   : synchronous clear (wins over iEn)
//   iEn    : add iBit to the count on this edge
//   iBit   : bitstream input
//   oCnt   : BITWIDTH+1 bit count, holds 2^BITWIDTH without wrapping
module usfft_ones_cnt #(
    parameter int BITWIDTH = 8,
    localparam int CW = BITWIDTH + 1
) (
    input  logic          iClk,
    input  logic          iRstN,
    input  logic          iClr,
    input  logic          iEn,
    input  logic          iBit,
    output logic [CW-1:0] oCnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iEn) begin
            cnt_d = cnt_q + CW'(iBit);
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oCnt = cnt_q;

endmodule

// File: rtl/usfft_bin_collect.sv
// Bin collector behind the unary radix-2 butterfly. Counts ones on the four
// output bitstreams over a window of 2^BITWIDTH enabled cycles, converts each
// count to a signed bipolar value (2*cnt - N), applies a saturating left shift
// of SCALE, and presents all four results with a one-cycle valid pulse.
//   iClk, iRstN       : clock (rising edge), asynchronous active-low reset
//   iEn               : sample enable; window pauses while low
//   iStart            : begin a window (honoured in IDLE only)
//   iClr              : synchronous abort to IDLE, wins over iStart
//   iReal0..iImg1     : butterfly output bitstreams
//   oBusy             : high while the window is running
//   oValid            : one-cycle pulse, results change in the same cycle
//   oReal0..oImg1     : OW-bit signed results, held until the next oValid
module usfft_bin_collect
    import usfft_bin_collect_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int SCALE    = 0,
    localparam int OW      = usfft_ow(BITWIDTH)
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    input  logic                 iEn,
    input  logic                 iStart,
    input  logic                 iClr,
    input  logic                 iReal0,
    input  logic                 iImg0,
    input  logic                 iReal1,
    input  logic                 iImg1,
    output logic                 oBusy,
    output logic                 oValid,
    output logic signed [OW-1:0] oReal0,
    output logic signed [OW-1:0] oImg0,
    output logic signed [OW-1:0] oReal1,
    output logic signed [OW-1:0] oImg1
);

    localparam int CW = BITWIDTH + 1;
    // Working width large enough that the shift can never overflow before saturation.
    localparam int WW = OW + SCALE;
    localparam logic [CW-1:0]        NSAMP   = {1'b1, {BITWIDTH{1'b0}}};
    localparam logic signed [WW-1:0] SAT_MAX = {{(SCALE + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = -SAT_MAX;

    logic [NUM_CH-1:0] bits;
    logic [CW-1:0]     cnt [NUM_CH];

    state_t                state_q, state_d;
    logic [CW-1:0]         smp_q, smp_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic signed [OW-1:0]  res_q [NUM_CH];
    logic signed [OW-1:0]  res_d [NUM_CH];
    logic                  cnt_clr;
    logic                  cnt_en;
    logic [CW-1:0]         smp_inc;

    assign bits    = {iImg1, iReal1, iImg0, iReal0};
    assign smp_inc = smp_q + 1'b1;

    function automatic logic signed [OW-1:0] to_bipolar(input logic [CW-1:0] c);
        logic signed [WW-1:0] b;
        b = $signed({{(WW - CW){1'b0}}, c});
        b = (b <<< 1) - $signed(WW'(NSAMP));
        b = b <<< SCALE;
        if (b > SAT_MAX) begin
            b = SAT_MAX;
        end else if (b < SAT_MIN) begin
            b = SAT_MIN;
        end
        return b[OW-1:0];
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        usfft_ones_cnt #(
            .BITWIDTH (BITWIDTH)
        ) u_cnt (
            .iClk  (iClk),
            .iRstN (iRstN),
            .iClr  (cnt_clr),
            .iEn   (cnt_en),
            .iBit  (bits[g]),
            .oCnt  (cnt[g])
        );
    end

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            res_d[i] = res_q[i];
        end

        if (iClr) begin
            state_d = ST_IDLE;
            smp_d   = '0;
            busy_d  = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        state_d = ST_RUN;
                        smp_d   = '0;
                        busy_d  = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (iEn) begin
                        smp_d  = smp_inc;
                        cnt_en = 1'b1;
                        // Results and valid are registered on the final sample edge so they
                        // appear together in DONE; the last bit is folded in here because the
                        // counters only absorb it on this same edge.
                        if (smp_inc == NSAMP) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            valid_d = 1'b1;
                            for (int unsigned i = 0; i < NUM_CH; i++) begin
                                res_d[i] = to_bipolar(cnt[i] + CW'(bits[i]));
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            smp_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                res_q[i] <= res_d[i];
            end
        end
    end

    assign oBusy  = busy_q;
    assign oValid = valid_q;
    assign oReal0 = res_q[0];
    assign oImg0  = res_q[1];
    assign oReal1 = res_q[2];
    assign oImg1  = res_q[3];

endmodule

// File: tb/tb_usfft_bin_collect.sv
module tb_usfft_bin_collect;

    localparam int N = 256;

    logic iClk;
    logic iRstN;
    logic iEn;
    logic iStart;
    logic iClr;
    logic [3:0] b_in;

    logic busy0, valid0, busy2, valid2;
    logic signed [9:0] o0 [4];
    logic signed [9:0] o2 [4];

    int checks = 0;
    int errors = 0;
    int held0 [4];
    int held2 [4];

    usfft_bin_collect #(
        .BITWIDTH (8),
        .SCALE    (0)
    ) u_dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iStart (iStart),
        .iClr   (iClr),
        .iReal0 (b_in[0]),
        .iImg0  (b_in[1]),
        .iReal1 (b_in[2]),
        .iImg1  (b_in[3]),
        .oBusy  (busy0),
        .oValid (valid0),
        .oReal0 (o0[0]),
        .oImg0  (o0[1]),
        .oReal1 (o0[2]),
        .oImg1  (o0[3])
    );

    usfft_bin_collect #(
        .BITWIDTH (8),
        .SCALE    (2)
    ) u_dut_s2 (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iStart (iStart),
        .iClr   (iClr),
        .iReal0 (b_in[0]),
        .iImg0  (b_in[1]),
        .iReal1 (b_in[2]),
        .iImg1  (b_in[3]),
        .oBusy  (busy2),
        .oValid (valid2),
        .oReal0 (o2[0]),
        .oImg0  (o2[1]),
        .oReal1 (o2[2]),
        .oImg1  (o2[3])
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference conversion straight from the arithmetic definition.
    function automatic int ref_result(input int ones, input int scale);
        int r;
        r = (2 * ones - N) * (1 << scale);
        if (r > 511) r = 511;
        if (r < -511) r = -511;
        return r;
    endfunction

    function automatic bit gen_bit(input int mode, input int ch, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (k % 2 == 0);
            3:       return (ch == 0);
            default: return 1'($urandom_range(1));
        endcase
    endfunction

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk_res(input string tag);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s_s0_ch%0d", tag, c), o0[c], held0[c]);
            chk($sformatf("%s_s2_ch%0d", tag, c), o2[c], held2[c]);
        end
    endtask

    // abort_kind: 0 = full window, 1 = iClr after abort_at samples, 2 = reset after abort_at samples
    task automatic run_window(input int mode, input int en_pct, input int abort_kind,
                              input int abort_at, input string tag);
        int  ones [4];
        int  k;
        int  guard;
        bit  en;
        bit  bv [4];
        bit  bad_run;
        ones    = '{default: 0};
        k       = 0;
        guard   = 0;
        bad_run = 0;

        // Start cycle with iEn and all bits high: none of it may be counted.
        iStart = 1'b1;
        iEn    = 1'b1;
        b_in   = 4'b1111;
        step();
        iStart = 1'b0;
        chk({tag, "_busy_start"}, busy0, 1);

        while (k < N && guard < 4 * N + 100) begin
            if (abort_kind != 0 && k == abort_at) break;
            en = ($urandom_range(99) < en_pct);
            for (int c = 0; c < 4; c++) bv[c] = gen_bit(mode, c, k);
            iEn    = en;
            b_in   = {bv[3], bv[2], bv[1], bv[0]};
            iStart = ($urandom_range(9) == 0);
            if (en) begin
                for (int c = 0; c < 4; c++) ones[c] += int'(bv[c]);
                k++;
            end
            guard++;
            step();
            if (k < N && (valid0 !== 1'b0 || busy0 !== 1'b1 || valid2 !== 1'b0)) bad_run = 1;
        end
        iStart = 1'b0;
        iEn    = 1'b0;
        chk({tag, "_run_flags"}, bad_run, 0);

        if (abort_kind == 0) begin
            chk({tag, "_samples_in_budget"}, k, N);
            chk({tag, "_valid"}, valid0, 1);
            chk({tag, "_valid_s2"}, valid2, 1);
            chk({tag, "_busy_done"}, busy0, 0);
            for (int c = 0; c < 4; c++) begin
                held0[c] = ref_result(ones[c], 0);
                held2[c] = ref_result(ones[c], 2);
            end
            chk_res(tag);
            step();
            chk({tag, "_valid_pulse"}, valid0, 0);
            chk_res({tag, "_hold"});
        end else if (abort_kind == 1) begin
            iClr = 1'b1;
            iEn  = 1'b1;
            step();
            iClr = 1'b0;
            chk({tag, "_clr_busy"}, busy0, 0);
            chk({tag, "_clr_valid"}, valid0, 0);
            bad_run = 0;
            for (int i = 0; i < 300; i++) begin
                step();
                if (valid0 !== 1'b0 || valid2 !== 1'b0 || busy0 !== 1'b0) bad_run = 1;
            end
            iEn = 1'b0;
            chk({tag, "_clr_idle"}, bad_run, 0);
            chk_res({tag, "_clr_hold"});
        end else begin
            #2;
            iRstN = 1'b0;
            #1;
            chk({tag, "_rst_busy"}, busy0, 0);
            chk({tag, "_rst_valid"}, valid0, 0);
            held0 = '{default: 0};
            held2 = '{default: 0};
            chk_res({tag, "_rst"});
            @(negedge iClk);
            iRstN = 1'b1;
            iEn   = 1'b1;
            for (int i = 0; i < 300; i++) step();
            iEn = 1'b0;
            chk({tag, "_rst_idle_valid"}, valid0, 0);
            chk({tag, "_rst_idle_busy"}, busy0, 0);
            chk_res({tag, "_rst_after"});
        end
        step();
    endtask

    initial begin
        iRstN  = 1'b0;
        iEn    = 1'b0;
        iStart = 1'b0;
        iClr   = 1'b0;
        b_in   = 4'b0000;
        held0  = '{default: 0};
        held2  = '{default: 0};
        repeat (3) @(posedge iClk);
        #1;
        chk("reset_busy", busy0, 0);
        chk("reset_valid", valid0, 0);
        chk_res("reset");
        @(negedge iClk);
        iRstN = 1'b1;
        step();

        run_window(0, 100, 0, 0, "all_ones");
        run_window(1, 100, 0, 0, "all_zeros");
        run_window(2, 100, 0, 0, "alternating");
        run_window(3, 100, 0, 0, "real0_only");
        run_window(0, 50, 0, 0, "en_toggle");
        run_window(4, 70, 0, 0, "random_a");
        run_window(4, 100, 1, 100, "clr_abort");
        run_window(3, 100, 0, 0, "after_clr");
        run_window(4, 100, 2, 50, "rst_abort");
        run_window(0, 100, 0, 0, "after_rst");
        run_window(4, 60, 0, 0, "random_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
